// File: rtl/spike_arbiter.sv
// Round-robin arbiter serializing single-cycle neuron spikes onto one
// valid/ready synapse channel, with saturating count of overlapping spikes.
module spike_arbiter #(
    parameter int N_NEURONS  = 2,
    parameter int ID_W       = 1,
    parameter int GAP_CYCLES = 0,
    parameter int DROP_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ID_W-1:0]      out_id,
    output logic [N_NEURONS-1:0] pending,
    output logic [DROP_W-1:0]    drop_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GAP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_W-1:0]        r_out_id;
    logic [ID_W-1:0]        w_out_id_nxt;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        w_ptr_nxt;
    logic [ID_W-1:0]        w_winner;
    logic                   w_any;
    logic [7:0]             r_gap_cnt;
    logic [7:0]             w_gap_cnt_nxt;
    logic [N_NEURONS-1:0]   r_pending;
    logic [N_NEURONS-1:0]   w_pending_nxt;
    logic [N_NEURONS-1:0]   w_clear;
    logic [N_NEURONS-1:0]   w_rot;
    logic [DROP_W-1:0]      r_drop;
    logic [DROP_W-1:0]      w_drop_nxt;
    logic [3:0]             w_drop_inc;
    logic [DROP_W+3:0]      w_drop_sum;
    logic                   w_hs;

    assign w_hs = (r_state == ST_OFFER) && out_ready;

    // Rotate pending so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        w_rot    = N_NEURONS'({r_pending, r_pending} >> r_ptr);
        w_any    = 1'b0;
        w_winner = '0;
        for (int unsigned k = 0; k < N_NEURONS; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any    = 1'b1;
                w_winner = ID_W'((32'(r_ptr) + k) % N_NEURONS);
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_hs) begin
            if (r_out_id == ID_W'(N_NEURONS - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = r_out_id + ID_W'(1);
            end
        end
    end

    // A spike landing on its own bit's clear cycle re-arms it and is not a drop.
    always_comb begin
        w_clear    = '0;
        w_drop_inc = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            w_clear[i] = w_hs && (r_out_id == ID_W'(i));
            if (spike_in[i] && r_pending[i] && !w_clear[i]) begin
                w_drop_inc = w_drop_inc + 4'd1;
            end
        end
        w_pending_nxt = (r_pending & ~w_clear) | spike_in;
        w_drop_sum    = (DROP_W+4)'(r_drop) + (DROP_W+4)'(w_drop_inc);
        if (w_drop_sum > (DROP_W+4)'({DROP_W{1'b1}})) begin
            w_drop_nxt = '1;
        end else begin
            w_drop_nxt = DROP_W'(w_drop_sum);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_out_id_nxt  = r_out_id;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt  = ST_OFFER;
                    w_out_id_nxt = w_winner;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = 8'(GAP_CYCLES);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                if (r_gap_cnt <= 8'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_out_id  <= '0;
            r_ptr     <= '0;
            r_gap_cnt <= '0;
            r_pending <= '0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_id  <= w_out_id_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    assign out_valid  = (r_state == ST_OFFER);
    assign out_id     = r_out_id;
    assign pending    = r_pending;
    assign drop_count = r_drop;
    assign busy       = (r_state != ST_IDLE) || (|r_pending);

endmodule

// File: doc/spike_arbiter.md
# spike_arbiter

Round-robin arbiter that shares a single synapse/output channel between N neuron spike sources. Each single-cycle neuron spike is latched as a pending request, granted in fair rotating order, and presented downstream through a valid/ready handshake tagged with the source index. It sits between the neuron array and the shared synapse path, replacing a plain OR of spikes so that simultaneous spikes are serialized, not merged, and lost spikes are counted.

## Interface
- N_NEURONS, 2: number of spike sources; legal 2..8.
- ID_W, 1: width of out_id; must satisfy 2^ID_W >= N_NEURONS.
- GAP_CYCLES, 0: idle cycles forced after each accepted grant (channel dead time); legal 0..255.
- DROP_W, 8: width of the drop counter.

- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- spike_in  input  N_NEURONS  per-neuron spike pulses; bit i high for one cycle per spike.
- out_ready  input  1  downstream synapse can accept a spike this cycle.
- out_valid  output  1  granted spike offered to downstream.
- out_id  output  ID_W  index of the neuron whose spike is offered; valid only while out_valid.
- pending  output  N_NEURONS  latched, not-yet-granted requests.
- drop_count  output  DROP_W  saturating count of spikes lost to an already-pending request.
- busy  output  1  high when state is not IDLE or any pending bit is set.

## Operation
- Pending latch, per bit i each cycle: next = (pending[i] and not clear_i) or spike_in[i]; clear_i = handshake this cycle with out_id == i.
- Drop: spike_in[i]=1 while pending[i]=1 and not clear_i. drop_count += number of such bits in that cycle, saturating at 2^DROP_W-1. A spike coinciding with the clear of its own bit re-sets pending and is not a drop.
- Rotation pointer ptr (ID_W bits): search starts at ptr, wraps from N_NEURONS-1 to 0; first set pending bit wins. After handshake ptr = (granted id + 1) mod N_NEURONS.
- FSM states IDLE, OFFER, GAP:
  - IDLE: if any pending bit set, register winner into out_id, set out_valid, go OFFER; else stay.
  - OFFER: out_valid=1, out_id held stable. On out_ready=1 (handshake): clear pending[out_id], update ptr, deassert out_valid next cycle; go GAP with counter=GAP_CYCLES if GAP_CYCLES>0, else IDLE. Without out_ready, stay; newly arriving higher-priority requests never change out_id.
  - GAP: decrement counter each cycle; at counter==1 go IDLE. No grants in GAP; pending still accumulates.
- Reset: state IDLE, out_valid=0, out_id=0, pending=0, drop_count=0, ptr=0, busy=0. Reset in any state, including mid-OFFER, discards all pending spikes; out_valid is 0 the cycle after reset is sampled.

## Timing
- Best-case latency: spike_in[i] high in cycle 0 -> pending[i] high cycle 1 -> out_valid high cycle 2 with out_id=i.
- Handshake in cycle k (out_valid & out_ready) -> out_valid low in cycle k+1 regardless of remaining requests.
- Back-to-back, GAP_CYCLES=0: out_valid pulses on every second cycle at most (OFFER, IDLE, OFFER, ...); max throughput one spike per 2 cycles.
- GAP_CYCLES=G>0: next out_valid no earlier than cycle k+G+2.
- out_id, out_valid change only on rising clk edges; out_valid never drops without a handshake except on reset.

## Test plan
- Single spike: N=2, spike_in=01 in cycle 0, out_ready=1 -> out_valid=1, out_id=0 in cycle 2; pending=00 in cycle 3; drop_count=0.
- Simultaneous spikes: N=4, spike_in=1111 in one cycle, out_ready=1 -> grants with out_id 0,1,2,3 in order on cycles 2,4,6,8; then a second 1111 burst -> order 0,1,2,3 again (ptr wrapped to 0).
- Backpressure: out_ready=0 for 10 cycles while offering id 1, spike_in[0] pulses meanwhile -> out_id stays 1 all 10 cycles; after out_ready=1, next grant is id 0.
- Drops: hold out_ready=0, pulse spike_in[1] three times -> pending[1]=1, drop_count=2; DROP_W=2 with 6 drops -> drop_count saturates at 3.
- Gap: GAP_CYCLES=3, two pending, out_ready=1 -> handshake at cycle k, next out_valid at cycle k+5.
- Reset mid-OFFER: assert reset while out_valid=1 and pending=0110 -> cycle after: out_valid=0, pending=0000, drop_count=0; first post-reset grant uses ptr=0.
